fsm_job_sequencer: RTL and testbench
====================================

// Module: fsm_job_sequencer
// PURPOSE
//  Parametrised job-control FSM that sequences one job: start -> init -> run -> done/error.
//  Extends the basic controller with a configurable init phase, a RUN watchdog timeout,
//  bounded automatic retry on error, an abort input, encoded fault reporting and
//  clear-to-idle so the block can be reused. Sits between the host command logic and
//  one datapath engine.
// PARAMETERS
//  INIT_CYCLES     1   cycles spent in INIT per attempt; must be >= 1
//  TIMEOUT_CYCLES  0   max cycles in RUN before a timeout fault; 0 = watchdog disabled
//  MAX_RETRIES     0   error-triggered re-runs allowed before ERROR; 0 = no retry
//  TMR_W           16  width of the init/RUN cycle counter; must hold max(INIT_CYCLES, TIMEOUT_CYCLES)
//  RTY_W           4   width of retry_cnt; must hold MAX_RETRIES
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      begin job; sampled only in IDLE
//  done        in   1      engine finished; sampled only in RUN
//  error       in   1      engine error; sampled only in RUN
//  abort       in   1      force fault; sampled only in INIT/RUN
//  clear       in   1      return to IDLE; sampled only in DONE/ERROR
//  busy        out  1      1 in INIT and RUN
//  valid       out  1      1 in DONE
//  fault       out  1      1 in ERROR
//  fault_code  out  2      00 none, 01 error with retries exhausted, 10 timeout, 11 abort
//  retry_cnt   out  RTY_W  retries consumed in the current job
//  state       out  3      IDLE=000, INIT=001, RUN=010, DONE=011, ERROR=100
// BEHAVIOUR
//  Output timing
//  - Moore machine. All outputs are decoded from registers; no combinational input->output path.
//  Reset
//  - state=IDLE. busy=valid=fault=0. fault_code=00. retry_cnt=0. Counters=0.
//  - Reset wins over every other input, in any state, including mid-job.
//  IDLE
//  - start=1 -> INIT. retry_cnt<=0, fault_code<=00, counter<=0.
//  INIT
//  - Counter increments each cycle. At counter==INIT_CYCLES-1 -> RUN and counter<=0.
//  - Exactly INIT_CYCLES cycles are spent in INIT.
//  - done and error are ignored.
//  RUN
//  - Counter increments each cycle. Priority is abort > error > done > timeout.
//  - error, retry_cnt<MAX_RETRIES -> INIT, retry_cnt+1, counter<=0.
//  - error, retry_cnt==MAX_RETRIES -> ERROR, code 01.
//  - done -> DONE.
//  - Timeout: TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no done/error
//    -> ERROR, code 10. RUN therefore lasts at most TIMEOUT_CYCLES cycles.
//  - Timeout never triggers a retry.
//  abort (INIT or RUN)
//  - -> ERROR, code 11, in the next cycle.
//  DONE / ERROR
//  - Sticky. clear=1 -> IDLE next cycle; fault_code<=00, retry_cnt<=0.
//  - start is ignored here.
//  - fault_code and retry_cnt hold their values until clear.
//  Ignored inputs
//  - start while busy. clear in IDLE/INIT/RUN. abort in IDLE/DONE/ERROR.
//  Latency
//  - start at edge t -> busy=1 after t.
//  - RUN is entered after edge t+INIT_CYCLES.
//  - done/error/abort at an edge -> valid/fault asserted after that edge.
//  Counters
//  - Counters never wrap in legal configurations.
//  - retry_cnt saturates at MAX_RETRIES.
// TESTING
//  T1 defaults: start@c0 -> busy=1,state=001 @c1; state=010 @c2; done@c5 -> valid=1,busy=0 @c6;
//     valid held 10 cycles; clear -> state=000, valid=0 next cycle.
//  T2 INIT_CYCLES=3, MAX_RETRIES=2: error on every RUN entry -> retry_cnt 1 then 2, each with
//     3 INIT cycles; third error -> fault=1, fault_code=01, retry_cnt=2.
//  T3 TIMEOUT_CYCLES=8: start, no done -> ERROR, fault_code=10, exactly 8 cycles after RUN entry;
//     done asserted in the 8th RUN cycle instead -> DONE, no fault.
//  T4 abort in 2nd INIT cycle (INIT_CYCLES=4) -> ERROR, fault_code=11 next cycle;
//     clear -> IDLE, fault_code=00.
//  T5 done+error same RUN cycle -> error path taken; abort+done same cycle -> code 11;
//     start during DONE ignored.
//  T6 reset asserted mid-RUN with retry_cnt=1 -> next cycle state=000, all outputs 0,
//     retry_cnt=0; new start runs normally.

Source files
------------

// File: rtl/fsm_job_sequencer.sv
// Job-control FSM: IDLE -> INIT -> RUN -> DONE/ERROR, with an init phase, a RUN watchdog,
// bounded retry on engine error, abort, encoded fault reporting and clear-to-idle.
module fsm_job_sequencer #(
  parameter int INIT_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int MAX_RETRIES    = 0,
  parameter int TMR_W          = 16,
  parameter int RTY_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic             error,
  input  logic             abort,
  input  logic             clear,
  output logic             busy,
  output logic             valid,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_INIT  = 3'b001;
  localparam logic [2:0] S_RUN   = 3'b010;
  localparam logic [2:0] S_DONE  = 3'b011;
  localparam logic [2:0] S_ERROR = 3'b100;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_RETRY = 2'b01;
  localparam logic [1:0] C_TMO   = 2'b10;
  localparam logic [1:0] C_ABORT = 2'b11;

  localparam logic [TMR_W-1:0] INIT_LAST = TMR_W'(INIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic             TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

  logic [2:0]       r_state;
  logic [TMR_W-1:0] r_cnt;
  logic [RTY_W-1:0] r_rty;
  logic [1:0]       r_code;

  logic [2:0]       w_state_nxt;
  logic [TMR_W-1:0] w_cnt_nxt;
  logic [RTY_W-1:0] w_rty_nxt;
  logic [1:0]       w_code_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rty   <= '0;
      r_code  <= C_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rty   <= w_rty_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // One shared counter times both the INIT phase and the RUN watchdog; it restarts on every phase change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rty_nxt   = r_rty;
    w_code_nxt  = r_code;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
          w_rty_nxt   = '0;
          w_code_nxt  = C_NONE;
        end
      end
      S_INIT: begin
        if (abort) begin
          w_state_nxt = S_ERROR;
          w_code_nxt  = C_ABORT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == INIT_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (abort) begin
          w_state_nxt = S_ERROR;
          w_code_nxt  = C_ABORT;
        end else if (error) begin
          // retry_cnt only ever climbs to RTY_MAX, so inequality means a retry is still available
          if (r_rty != RTY_MAX) begin
            w_state_nxt = S_INIT;
            w_rty_nxt   = r_rty + 1'b1;
          end else begin
            w_state_nxt = S_ERROR;
            w_code_nxt  = C_RETRY;
          end
        end else if (done) begin
          w_state_nxt = S_DONE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_state_nxt = S_ERROR;
          w_code_nxt  = C_TMO;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
          w_code_nxt  = C_NONE;
          w_rty_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_rty_nxt   = '0;
        w_code_nxt  = C_NONE;
      end
    endcase
  end

  always_comb begin
    busy       = (r_state == S_INIT) || (r_state == S_RUN);
    valid      = (r_state == S_DONE);
    fault      = (r_state == S_ERROR);
    fault_code = r_code;
    retry_cnt  = r_rty;
    state      = r_state;
  end

endmodule

// File: tb/tb_fsm_job_sequencer.sv
// Directed bench for fsm_job_sequencer: three instances cover the default, retry/timeout
// and long-INIT configurations; all expected values are hand-derived constants.
module tb_fsm_job_sequencer;

  logic clk;
  logic reset;

  // default instance (INIT_CYCLES=1, no watchdog, no retry)
  logic       d_start, d_done, d_error, d_abort, d_clear;
  logic       d_busy, d_valid, d_fault;
  logic [1:0] d_code;
  logic [3:0] d_rty;
  logic [2:0] d_state;

  // INIT_CYCLES=3, TIMEOUT_CYCLES=8, MAX_RETRIES=2
  logic       c_start, c_done, c_error, c_abort, c_clear;
  logic       c_busy, c_valid, c_fault;
  logic [1:0] c_code;
  logic [3:0] c_rty;
  logic [2:0] c_state;

  // INIT_CYCLES=4
  logic       a_start, a_done, a_error, a_abort, a_clear;
  logic       a_busy, a_valid, a_fault;
  logic [1:0] a_code;
  logic [3:0] a_rty;
  logic [2:0] a_state;

  int n_chk;
  int n_fail;

  fsm_job_sequencer u_def (
    .clk(clk), .reset(reset), .start(d_start), .done(d_done), .error(d_error),
    .abort(d_abort), .clear(d_clear), .busy(d_busy), .valid(d_valid), .fault(d_fault),
    .fault_code(d_code), .retry_cnt(d_rty), .state(d_state)
  );

  fsm_job_sequencer #(.INIT_CYCLES(3), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) u_cfg (
    .clk(clk), .reset(reset), .start(c_start), .done(c_done), .error(c_error),
    .abort(c_abort), .clear(c_clear), .busy(c_busy), .valid(c_valid), .fault(c_fault),
    .fault_code(c_code), .retry_cnt(c_rty), .state(c_state)
  );

  fsm_job_sequencer #(.INIT_CYCLES(4)) u_ab (
    .clk(clk), .reset(reset), .start(a_start), .done(a_done), .error(a_error),
    .abort(a_abort), .clear(a_clear), .busy(a_busy), .valid(a_valid), .fault(a_fault),
    .fault_code(a_code), .retry_cnt(a_rty), .state(a_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance one rising edge, then settle past it before sampling or driving
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    {d_start, d_done, d_error, d_abort, d_clear} = '0;
    {c_start, c_done, c_error, c_abort, c_clear} = '0;
    {a_start, a_done, a_error, a_abort, a_clear} = '0;
    tick(2);
    reset = 1'b0;

    chk("rst_state", d_state, 0);
    chk("rst_busy",  d_busy,  0);
    chk("rst_valid", d_valid, 0);
    chk("rst_fault", d_fault, 0);
    chk("rst_code",  d_code,  0);
    chk("rst_rty",   d_rty,   0);
    chk("rst_cfg_state", c_state, 0);
    chk("rst_ab_state",  a_state, 0);

    // T1: default job
    d_start = 1'b1; tick; d_start = 1'b0;
    chk("t1_init_state", d_state, 3'b001);
    chk("t1_init_busy",  d_busy, 1);
    tick;
    chk("t1_run_state", d_state, 3'b010);
    tick(3);
    chk("t1_run_hold", d_state, 3'b010);
    d_done = 1'b1; tick; d_done = 1'b0;
    chk("t1_done_state", d_state, 3'b011);
    chk("t1_done_valid", d_valid, 1);
    chk("t1_done_busy",  d_busy, 0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t1_valid_hold", d_valid, 1);
    end
    d_clear = 1'b1; tick; d_clear = 1'b0;
    chk("t1_clr_state", d_state, 0);
    chk("t1_clr_valid", d_valid, 0);

    // no retries allowed: first error is final
    d_start = 1'b1; tick; d_start = 1'b0;
    tick;
    chk("t1b_run", d_state, 3'b010);
    d_error = 1'b1; tick; d_error = 1'b0;
    chk("t1b_err_state", d_state, 3'b100);
    chk("t1b_err_code",  d_code, 2'b01);
    chk("t1b_err_rty",   d_rty, 0);
    chk("t1b_err_fault", d_fault, 1);
    d_start = 1'b1; tick; d_start = 1'b0;
    chk("t1b_start_ign", d_state, 3'b100);
    d_clear = 1'b1; tick; d_clear = 1'b0;
    chk("t1b_clr", d_state, 0);

    // T2: retries, error held high across INIT (ignored there)
    c_start = 1'b1; tick; c_start = 1'b0;
    chk("t2_init0", c_state, 3'b001);
    c_error = 1'b1;
    tick; chk("t2_init1", c_state, 3'b001);
    tick; chk("t2_init2", c_state, 3'b001);
    tick; chk("t2_run_a", c_state, 3'b010);
    tick;
    chk("t2_retry1_state", c_state, 3'b001);
    chk("t2_retry1_cnt",   c_rty, 1);
    tick; chk("t2_r1_init1", c_state, 3'b001);
    tick; chk("t2_r1_init2", c_state, 3'b001);
    tick; chk("t2_run_b", c_state, 3'b010);
    tick;
    chk("t2_retry2_state", c_state, 3'b001);
    chk("t2_retry2_cnt",   c_rty, 2);
    tick(2);
    chk("t2_r2_init", c_state, 3'b001);
    tick; chk("t2_run_c", c_state, 3'b010);
    tick; c_error = 1'b0;
    chk("t2_err_state", c_state, 3'b100);
    chk("t2_err_fault", c_fault, 1);
    chk("t2_err_code",  c_code, 2'b01);
    chk("t2_err_rty",   c_rty, 2);
    chk("t2_err_busy",  c_busy, 0);
    tick(2);
    chk("t2_code_hold", c_code, 2'b01);
    c_clear = 1'b1; tick; c_clear = 1'b0;
    chk("t2_clr_state", c_state, 0);
    chk("t2_clr_code",  c_code, 0);
    chk("t2_clr_rty",   c_rty, 0);

    // T3: watchdog fires after exactly 8 RUN cycles
    c_start = 1'b1; tick; c_start = 1'b0;
    tick(3);
    chk("t3_run_entry", c_state, 3'b010);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("t3_run_hold", c_state, 3'b010);
    end
    tick;
    chk("t3_tmo_state", c_state, 3'b100);
    chk("t3_tmo_code",  c_code, 2'b10);
    chk("t3_tmo_rty",   c_rty, 0);
    c_clear = 1'b1; tick; c_clear = 1'b0;
    chk("t3_clr", c_state, 0);

    // done in the 8th RUN cycle beats the watchdog
    c_start = 1'b1; tick; c_start = 1'b0;
    tick(3);
    tick(7);
    chk("t3b_run_last", c_state, 3'b010);
    c_done = 1'b1; tick; c_done = 1'b0;
    chk("t3b_done_state", c_state, 3'b011);
    chk("t3b_done_fault", c_fault, 0);
    chk("t3b_done_code",  c_code, 0);
    // T5: start during DONE ignored
    c_start = 1'b1; tick; c_start = 1'b0;
    chk("t5_start_ign", c_state, 3'b011);
    c_clear = 1'b1; tick; c_clear = 1'b0;
    chk("t3b_clr", c_state, 0);

    // T5: done+error takes the error (retry) path; abort+done gives abort
    c_start = 1'b1; tick; c_start = 1'b0;
    tick(3);
    {c_done, c_error} = 2'b11; tick; {c_done, c_error} = 2'b00;
    chk("t5_de_state", c_state, 3'b001);
    chk("t5_de_rty",   c_rty, 1);
    tick(3);
    chk("t5_run", c_state, 3'b010);
    c_clear = 1'b1; tick; c_clear = 1'b0;
    chk("t5_clr_ign_run", c_state, 3'b010);
    {c_abort, c_done} = 2'b11; tick; {c_abort, c_done} = 2'b00;
    chk("t5_ad_state", c_state, 3'b100);
    chk("t5_ad_code",  c_code, 2'b11);
    chk("t5_ad_rty",   c_rty, 1);
    c_clear = 1'b1; tick; c_clear = 1'b0;
    chk("t5_clr", c_state, 0);

    // T4: abort in 2nd INIT cycle, INIT_CYCLES=4
    a_abort = 1'b1; tick; a_abort = 1'b0;
    chk("t4_abort_idle_ign", a_state, 0);
    a_start = 1'b1; tick; a_start = 1'b0;
    chk("t4_init0", a_state, 3'b001);
    tick;
    chk("t4_init1", a_state, 3'b001);
    a_abort = 1'b1; tick; a_abort = 1'b0;
    chk("t4_ab_state", a_state, 3'b100);
    chk("t4_ab_code",  a_code, 2'b11);
    chk("t4_ab_fault", a_fault, 1);
    a_clear = 1'b1; tick; a_clear = 1'b0;
    chk("t4_clr_state", a_state, 0);
    chk("t4_clr_code",  a_code, 0);
    // full INIT length: 4 cycles
    a_start = 1'b1; tick; a_start = 1'b0;
    tick(3);
    chk("t4_init3", a_state, 3'b001);
    tick;
    chk("t4_run", a_state, 3'b010);
    a_done = 1'b1; tick; a_done = 1'b0;
    chk("t4_done", a_valid, 1);
    a_clear = 1'b1; tick; a_clear = 1'b0;

    // T6: reset mid-RUN with retry_cnt=1
    c_start = 1'b1; tick; c_start = 1'b0;
    tick(3);
    c_error = 1'b1; tick; c_error = 1'b0;
    tick(3);
    chk("t6_run", c_state, 3'b010);
    chk("t6_rty", c_rty, 1);
    reset = 1'b1; tick; reset = 1'b0;
    chk("t6_rst_state", c_state, 0);
    chk("t6_rst_busy",  c_busy, 0);
    chk("t6_rst_valid", c_valid, 0);
    chk("t6_rst_fault", c_fault, 0);
    chk("t6_rst_code",  c_code, 0);
    chk("t6_rst_rty",   c_rty, 0);
    c_start = 1'b1; tick; c_start = 1'b0;
    chk("t6_init", c_state, 3'b001);
    tick(3);
    chk("t6_run2", c_state, 3'b010);
    c_done = 1'b1; tick; c_done = 1'b0;
    chk("t6_done", c_valid, 1);
    chk("t6_done_rty", c_rty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
